// File: rtl/seg_display_arbiter_if.sv
// Requester/display bundle for the shared seven-segment display.
// Requesters and the display sink sit on the master side; the arbiter is the slave.
interface seg_display_arbiter_if;
  logic        req_a;
  logic [31:0] data_a;
  logic        req_b;
  logic [31:0] data_b;
  logic        lz_en;
  logic        gnt_a;
  logic        gnt_b;
  logic [7:0]  seg;
  logic [7:0]  w_sel;
  logic        frame_done;

  modport master (
    output req_a, data_a, req_b, data_b, lz_en,
    input  gnt_a, gnt_b, seg, w_sel, frame_done
  );

  modport slave (
    input  req_a, data_a, req_b, data_b, lz_en,
    output gnt_a, gnt_b, seg, w_sel, frame_done
  );
endinterface

// File: rtl/seg_display_arbiter.sv
// Digit-scan timing plus frame-boundary arbitration of the 8-digit display
// between requesters A and B, showing a per-frame snapshot of the owner's BCD word.
module seg_display_arbiter #(
  parameter int SCAN_DIV     = 50000,
  parameter int MIN_FRAMES   = 4,
  parameter int BLANK_FRAMES = 1
) (
  input logic               clk,
  input logic               clr,
  seg_display_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B, BLANK} state_t;

  localparam int PW = $clog2(SCAN_DIV);

  logic [PW-1:0] presc;
  logic [2:0]    idx, idx_nxt;
  logic          tick, fdone;
  state_t        state, state_nxt;
  logic [15:0]   own_cnt, own_cnt_nxt, own_inc, blk_cnt, blk_cnt_nxt;
  logic          last_b, last_b_nxt;
  logic [31:0]   shadow, shadow_nxt, sh;
  logic          disp_en, en_nxt, en;
  logic [7:0]    lead;
  logic [3:0]    nib;
  logic [7:0]    seg_nxt, seg_q, wsel_q;

  function automatic logic [7:0] dec7(input logic [3:0] n);
    case (n)
      4'd0:    dec7 = 8'hC0;
      4'd1:    dec7 = 8'hF9;
      4'd2:    dec7 = 8'hA4;
      4'd3:    dec7 = 8'hB0;
      4'd4:    dec7 = 8'h99;
      4'd5:    dec7 = 8'h92;
      4'd6:    dec7 = 8'h82;
      4'd7:    dec7 = 8'hF8;
      4'd8:    dec7 = 8'h80;
      4'd9:    dec7 = 8'h90;
      default: dec7 = 8'hBF;
    endcase
  endfunction

  assign tick    = (presc == PW'(SCAN_DIV - 1));
  assign fdone   = tick && (idx == 3'd7);
  assign idx_nxt = idx + 3'd1;

  always_comb begin
    state_nxt   = state;
    own_cnt_nxt = own_cnt;
    blk_cnt_nxt = blk_cnt;
    last_b_nxt  = last_b;
    own_inc     = (own_cnt == 16'(MIN_FRAMES)) ? own_cnt : own_cnt + 16'd1;
    if (fdone) begin
      case (state)
        IDLE: begin
          if (bus.req_b) begin
            state_nxt = OWN_B; own_cnt_nxt = '0; last_b_nxt = 1'b1;
          end else if (bus.req_a) begin
            state_nxt = OWN_A; own_cnt_nxt = '0; last_b_nxt = 1'b0;
          end
        end
        OWN_A: begin
          own_cnt_nxt = own_inc;
          if (!bus.req_a || (bus.req_b && own_inc == 16'(MIN_FRAMES))) begin
            state_nxt = BLANK; blk_cnt_nxt = '0;
          end
        end
        OWN_B: begin
          own_cnt_nxt = own_inc;
          if (!bus.req_b || (bus.req_a && own_inc == 16'(MIN_FRAMES))) begin
            state_nxt = BLANK; blk_cnt_nxt = '0;
          end
        end
        default: begin
          blk_cnt_nxt = blk_cnt + 16'd1;
          if ((blk_cnt + 16'd1) >= 16'(BLANK_FRAMES)) begin
            own_cnt_nxt = '0;
            // Round-robin: the requester that did not own last gets first pick.
            if (last_b && bus.req_a) begin
              state_nxt = OWN_A; last_b_nxt = 1'b0;
            end else if (!last_b && bus.req_b) begin
              state_nxt = OWN_B; last_b_nxt = 1'b1;
            end else if (last_b && bus.req_b) begin
              state_nxt = OWN_B;
            end else if (!last_b && bus.req_a) begin
              state_nxt = OWN_A;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    shadow_nxt = '0;
    if (state_nxt == OWN_A) shadow_nxt = bus.data_a;
    else if (state_nxt == OWN_B) shadow_nxt = bus.data_b;
    en_nxt = (state_nxt == OWN_A) || (state_nxt == OWN_B);
    // Digit 0 of a new frame must already come from the incoming snapshot.
    sh = fdone ? shadow_nxt : shadow;
    en = fdone ? en_nxt : disp_en;
    lead[7] = (sh[31:28] == 4'd0);
    for (int i = 6; i >= 0; i--) lead[i] = lead[i+1] && (sh[4*i +: 4] == 4'd0);
    nib     = sh[4*idx_nxt +: 4];
    seg_nxt = dec7(nib);
    if (!en || (bus.lz_en && lead[idx_nxt] && idx_nxt != 3'd0)) seg_nxt = 8'hFF;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      presc   <= '0;
      idx     <= '0;
      state   <= IDLE;
      own_cnt <= '0;
      blk_cnt <= '0;
      last_b  <= 1'b0;
      shadow  <= '0;
      disp_en <= 1'b0;
      seg_q   <= 8'hFF;
      wsel_q  <= 8'h01;
    end else begin
      presc   <= tick ? '0 : presc + PW'(1);
      state   <= state_nxt;
      own_cnt <= own_cnt_nxt;
      blk_cnt <= blk_cnt_nxt;
      last_b  <= last_b_nxt;
      if (tick) begin
        idx    <= idx_nxt;
        wsel_q <= 8'd1 << idx_nxt;
        seg_q  <= seg_nxt;
      end
      if (fdone) begin
        shadow  <= shadow_nxt;
        disp_en <= en_nxt;
      end
    end
  end

  assign bus.gnt_a      = (state == OWN_A);
  assign bus.gnt_b      = (state == OWN_B);
  assign bus.seg        = seg_q;
  assign bus.w_sel      = wsel_q;
  assign bus.frame_done = fdone;
endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with SCAN_DIV=4, MIN_FRAMES=2, BLANK_FRAMES=1.
module tb_seg_display_arbiter;
  logic clk = 1'b0;
  logic clr = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  seg_display_arbiter_if bus ();

  seg_display_arbiter #(.SCAN_DIV(4), .MIN_FRAMES(2), .BLANK_FRAMES(1)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] F_12345678 = 64'hF9A4B0999282F880;
  localparam logic [63:0] F_87654321 = 64'h80F8829299B0A4F9;
  localparam logic [63:0] F_LZ470    = 64'hFFFFFFFFFF99F8C0;
  localparam logic [63:0] F_LZ0      = 64'hFFFFFFFFFFFFFFC0;
  localparam logic [63:0] F_BLANK    = 64'hFFFFFFFFFFFFFFFF;
  localparam logic [63:0] F_ONES     = 64'hF9F9F9F9F9F9F9F9;
  localparam logic [63:0] F_TWOS     = 64'hA4A4A4A4A4A4A4A4;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  // Returns at the negedge of the next frame_done cycle.
  task automatic wait_fd();
    int n = 0;
    @(negedge clk);
    while (!bus.frame_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.frame_done) chk("fd_timeout", 32'd0, 32'd1);
  endtask

  // Called at a frame_done negedge; reads the following frame and ends on its frame_done.
  task automatic check_frame(input string tag, input logic ga, input logic gb,
                             input logic [63:0] exp);
    logic [7:0] ws;
    for (int d = 0; d < 8; d++) begin
      @(negedge clk);
      ws = 8'd1 << d;
      if (d == 0) begin
        chk({tag, "_gnt_a"}, 32'(bus.gnt_a), 32'(ga));
        chk({tag, "_gnt_b"}, 32'(bus.gnt_b), 32'(gb));
      end
      chk($sformatf("%s_wsel%0d", tag, d), 32'(bus.w_sel), 32'(ws));
      chk($sformatf("%s_seg%0d", tag, d), 32'(bus.seg), 32'(exp[8*d +: 8]));
      repeat (3) @(negedge clk);
    end
    chk({tag, "_fd"}, 32'(bus.frame_done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ws;
    int n, wn;
    bus.req_a = 1'b0; bus.req_b = 1'b0; bus.lz_en = 1'b0;
    bus.data_a = '0;  bus.data_b = '0;

    // Reset and free scan
    repeat (3) @(negedge clk);
    chk("rst_wsel", 32'(bus.w_sel), 32'h01);
    chk("rst_seg",  32'(bus.seg),   32'hFF);
    chk("rst_gnt_a", 32'(bus.gnt_a), 32'd0);
    chk("rst_gnt_b", 32'(bus.gnt_b), 32'd0);
    chk("rst_fd",   32'(bus.frame_done), 32'd0);
    clr = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      ws = 8'd1 << ((k / 4) % 8);
      chk($sformatf("scan_wsel_k%0d", k), 32'(bus.w_sel), 32'(ws));
      chk($sformatf("scan_fd_k%0d", k), 32'(bus.frame_done), 32'((k % 32) == 31));
      chk($sformatf("scan_seg_k%0d", k), 32'(bus.seg), 32'hFF);
    end

    // Single owner, decode, mid-frame data change
    bus.req_a = 1'b1; bus.data_a = 32'h12345678;
    wait_fd();
    check_frame("own_a", 1'b1, 1'b0, F_12345678);
    repeat (12) @(negedge clk);
    bus.data_a = 32'h87654321;
    repeat (5) @(negedge clk);
    chk("mid_wsel", 32'(bus.w_sel), 32'h10);
    chk("mid_seg_old", 32'(bus.seg), 32'h99);
    wait_fd();
    check_frame("new_a", 1'b1, 1'b0, F_87654321);

    // Leading-zero suppression
    bus.lz_en = 1'b1; bus.data_a = 32'h00000470;
    check_frame("lz470", 1'b1, 1'b0, F_LZ470);
    bus.data_a = 32'h0;
    check_frame("lz0", 1'b1, 1'b0, F_LZ0);

    // Simultaneous request from IDLE and round-robin
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    bus.lz_en = 1'b0;
    bus.req_a = 1'b1; bus.data_a = 32'h11111111;
    bus.req_b = 1'b1; bus.data_b = 32'h22222222;
    wait_fd();
    check_frame("rr_b1", 1'b0, 1'b1, F_TWOS);
    check_frame("rr_b2", 1'b0, 1'b1, F_TWOS);
    check_frame("rr_bl1", 1'b0, 1'b0, F_BLANK);
    check_frame("rr_a1", 1'b1, 1'b0, F_ONES);
    check_frame("rr_a2", 1'b1, 1'b0, F_ONES);
    check_frame("rr_bl2", 1'b0, 1'b0, F_BLANK);
    bus.req_a = 1'b0;
    check_frame("rr_b3", 1'b0, 1'b1, F_TWOS);

    // Owner release mid-frame
    repeat (10) @(negedge clk);
    bus.req_b = 1'b0;
    repeat (2) @(negedge clk);
    chk("rel_hold_gnt_b", 32'(bus.gnt_b), 32'd1);
    wait_fd();
    check_frame("rel_blank", 1'b0, 1'b0, F_BLANK);
    check_frame("rel_idle", 1'b0, 1'b0, F_BLANK);

    // Reset during OWN_A at digit 5
    bus.req_a = 1'b1; bus.data_a = 32'h12345678;
    repeat (21) @(negedge clk);
    chk("pre_rst_gnt_a", 32'(bus.gnt_a), 32'd1);
    chk("pre_rst_wsel", 32'(bus.w_sel), 32'h20);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("mrst_gnt_a", 32'(bus.gnt_a), 32'd0);
    chk("mrst_wsel", 32'(bus.w_sel), 32'h01);
    chk("mrst_seg", 32'(bus.seg), 32'hFF);
    n = 0; wn = 0;
    while (!bus.gnt_a && n < 100) begin
      @(negedge clk);
      n++;
      if (wn == 0 && bus.w_sel == 8'h02) wn = n;
    end
    chk("mrst_presc_restart", 32'(wn), 32'd4);
    chk("mrst_regrant_cycles", 32'(n), 32'd32);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
